// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
//   Time-multiplexed scan controller for a 4-digit seven-segment display.
//   Each digit is preceded by a dark gap (all anodes off) to avoid ghosting,
//   then lit for SCAN_DIV cycles. New values arrive via a valid/ready port
//   into shadow registers and are committed only at frame boundaries, so
//   a frame never mixes old and new digits.
//
// Ports
//   clk         system clock, all state on rising edge
//   rst_n       asynchronous active-low reset
//   en          1 = scanning, 0 = display dark and FSM parked at digit0 BLANK
//   load_valid  load request
//   load_ready  controller can accept a load
//   load_data   nibble k (bits 4k+3:4k) shown on digit k
//   load_dp     bit k lights the decimal point of digit k
//   load_blank  bit k forces digit k segments (and dp) to 0
//   digi_out    [11:8] one-hot digit select, [7:0] {dp,g,f,e,d,c,b,a}
//   frame_done  one-cycle pulse after the end of digit-3 SHOW
// -----------------------------------------------------------------------------
module display_scan_ctrl #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500,
  parameter int CNT_W     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_data,
  input  logic [3:0]  load_dp,
  input  logic [3:0]  load_blank,
  output logic [11:0] digi_out,
  output logic        frame_done
);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  state_t           state_reg;
  logic [1:0]       digit_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [15:0] active_data_reg, shadow_data_reg;
  logic [3:0]  active_dp_reg, shadow_dp_reg;
  logic [3:0]  active_blank_reg, shadow_blank_reg;
  logic        pending_reg;

  // Active-high segment pattern {g,f,e,d,c,b,a} for a hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Segment byte for every digit from the committed (active) registers.
  logic [7:0] digit_seg [4];
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_seg
      assign digit_seg[gi] = active_blank_reg[gi] ? 8'h00
                           : {active_dp_reg[gi], hex7(active_data_reg[4*gi +: 4])};
    end
  endgenerate

  logic [11:0] lit_word;
  logic        transfer, show_last, blank_last, frame_end, commit;

  assign lit_word   = {4'(4'b0001 << digit_reg), digit_seg[digit_reg]};
  assign transfer   = load_valid & load_ready;
  assign show_last  = (state_reg == ST_SHOW)  && (cnt_reg == SHOW_LAST);
  assign blank_last = (state_reg == ST_BLANK) && (cnt_reg == BLANK_LAST);
  assign frame_end  = show_last && (digit_reg == 2'd3);
  // While disabled there is no frame to tear, so a pending load commits at once.
  assign commit     = pending_reg & (en ? frame_end : 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_BLANK;
      digit_reg        <= 2'd0;
      cnt_reg          <= '0;
      digi_out         <= 12'h000;
      frame_done       <= 1'b0;
      active_data_reg  <= '0;
      active_dp_reg    <= '0;
      active_blank_reg <= '0;
      shadow_data_reg  <= '0;
      shadow_dp_reg    <= '0;
      shadow_blank_reg <= '0;
      pending_reg      <= 1'b0;
      load_ready       <= 1'b1;
    end else begin
      // A transfer needs load_ready, which implies pending was clear, so
      // transfer and commit never coincide.
      if (transfer) begin
        shadow_data_reg  <= load_data;
        shadow_dp_reg    <= load_dp;
        shadow_blank_reg <= load_blank;
        pending_reg      <= 1'b1;
      end else if (commit) begin
        pending_reg      <= 1'b0;
      end
      // Ready follows pending one cycle late; a transfer drops it immediately
      // so the port can never accept twice in a row.
      load_ready <= ~(pending_reg | transfer);

      if (commit) begin
        active_data_reg  <= shadow_data_reg;
        active_dp_reg    <= shadow_dp_reg;
        active_blank_reg <= shadow_blank_reg;
      end

      if (!en) begin
        state_reg  <= ST_BLANK;
        digit_reg  <= 2'd0;
        cnt_reg    <= '0;
        digi_out   <= 12'h000;
        frame_done <= 1'b0;
      end else begin
        frame_done <= frame_end;
        case (state_reg)
          ST_BLANK: begin
            if (blank_last) begin
              state_reg <= ST_SHOW;
              cnt_reg   <= '0;
              digi_out  <= lit_word;
            end else begin
              cnt_reg   <= cnt_reg + 1'b1;
              digi_out  <= 12'h000;
            end
          end
          default: begin
            if (show_last) begin
              state_reg <= ST_BLANK;
              cnt_reg   <= '0;
              digit_reg <= digit_reg + 2'd1;
              digi_out  <= 12'h000;
            end else begin
              cnt_reg   <= cnt_reg + 1'b1;
              digi_out  <= lit_word;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_display_scan_ctrl
//   Directed bench for display_scan_ctrl with SCAN_DIV=4, BLANK_CYC=1
//   (20-cycle frame). The stimulus process pushes expected observations,
//   tagged with the absolute cycle they belong to, into a scoreboard queue;
//   a monitor on the falling edge pops and compares the entries due.
// -----------------------------------------------------------------------------
module tb_display_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [3:0]  load_dp;
  logic [3:0]  load_blank;
  logic [11:0] digi_out;
  logic        frame_done;

  display_scan_ctrl #(.SCAN_DIV(4), .BLANK_CYC(1), .CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_dp    (load_dp),
    .load_blank (load_blank),
    .digi_out   (digi_out),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc = number of rising edges so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    bit          is_rdy;   // 0: check {digi_out,frame_done}; 1: check load_ready
    logic [11:0] digi;
    logic        fd;
    logic        rdy;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic push_disp(input int c, input logic [11:0] d, input logic f, input string t);
    exp_t e;
    e.cyc = c; e.is_rdy = 1'b0; e.digi = d; e.fd = f; e.rdy = 1'b0; e.tag = t;
    exp_q.push_back(e);
  endtask

  task automatic push_rdy(input int c, input logic r, input string t);
    exp_t e;
    e.cyc = c; e.is_rdy = 1'b1; e.digi = 12'h000; e.fd = 1'b0; e.rdy = r; e.tag = t;
    exp_q.push_back(e);
  endtask

  // Expected observations for one frame starting at its digit0 dark cycle.
  // Cycle i of the frame: i%5==0 dark, otherwise digit i/5 lit.
  task automatic exp_frame(input int base, input logic [11:0] w0, input logic [11:0] w1,
                           input logic [11:0] w2, input logic [11:0] w3,
                           input bit first, input int ncyc, input string t);
    logic [11:0] w [4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int i = 0; i < ncyc; i++) begin
      push_disp(base + i, (i % 5 == 0) ? 12'h000 : w[i / 5],
                (i == 0) && !first, t);
    end
  endtask

  // Monitor: compare every scoreboard entry due in the current cycle.
  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc == cyc) begin
        total++;
        if (exp_q[i].is_rdy) begin
          if (load_ready !== exp_q[i].rdy) begin
            bad++;
            $display("FAIL %s cyc=%0d load_ready got=%b want=%b",
                     exp_q[i].tag, cyc, load_ready, exp_q[i].rdy);
          end
        end else if ({digi_out, frame_done} !== {exp_q[i].digi, exp_q[i].fd}) begin
          bad++;
          $display("FAIL %s cyc=%0d got digi=%03h fd=%b want digi=%03h fd=%b",
                   exp_q[i].tag, cyc, digi_out, frame_done, exp_q[i].digi, exp_q[i].fd);
        end
        exp_q.delete(i);
      end
    end
  end

  // Inputs change 2 time units after a rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) step();
  endtask

  // Hold a load until the handshake completes (bounded).
  task automatic send(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    logic r;
    int   n;
    load_data  = d;
    load_dp    = dp;
    load_blank = bl;
    load_valid = 1'b1;
    n = 0;
    do begin
      r = load_ready;
      step();
      n++;
    end while (!r && n < 200);
    load_valid = 1'b0;
    total++;
    if (!r) begin
      bad++;
      $display("FAIL load_timeout data=%04h got no ready want ready within 200 cycles", d);
    end else begin
      $display("load data=%04h dp=%b blank=%b accepted at edge %0d", d, dp, bl, cyc);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    en         = 1'b0;
    load_valid = 1'b0;
    load_data  = 16'h0000;
    load_dp    = 4'h0;
    load_blank = 4'h0;

    // Reset state.
    wait_cyc(2);
    push_disp(2, 12'h000, 1'b0, "reset_out");
    push_rdy(2, 1'b1, "reset_rdy");
    wait_cyc(3);
    rst_n = 1'b1;
    push_disp(4, 12'h000, 1'b0, "idle_dis_out");
    push_rdy(4, 1'b1, "idle_dis_rdy");

    // 1. Reset mid-SHOW with a pending load.
    wait_cyc(5);
    push_disp(6, 12'h13F, 1'b0, "t1_show0");
    push_rdy(6, 1'b0, "t1_pending_rdy");
    push_disp(7, 12'h000, 1'b0, "t1_reset_out");
    push_rdy(7, 1'b1, "t1_reset_rdy");
    en = 1'b1;
    send(16'h5555, 4'h0, 4'h0);
    wait_cyc(7);
    rst_n = 1'b0;
    wait_cyc(8);
    rst_n = 1'b1;
    exp_frame(8,  12'h13F, 12'h23F, 12'h43F, 12'h83F, 1'b1, 20, "t1_frame_a");
    exp_frame(28, 12'h13F, 12'h23F, 12'h43F, 12'h83F, 1'b0, 20, "t1_frame_b");
    push_rdy(9, 1'b1, "t1_rdy_after");

    // 2. Load 1234, shown from the frame after commit.
    wait_cyc(30);
    push_rdy(30, 1'b1, "t2_rdy_before");
    push_rdy(31, 1'b0, "t2_rdy_taken");
    push_rdy(48, 1'b0, "t2_rdy_fd");
    push_rdy(49, 1'b1, "t2_rdy_back");
    exp_frame(48, 12'h166, 12'h24F, 12'h45B, 12'h806, 1'b0, 20, "t2_frame_1234");
    send(16'h1234, 4'h0, 4'h0);

    // 3+4. ABCD with dp/blank, then a second load held while pending.
    wait_cyc(50);
    push_rdy(50, 1'b1, "t3_rdy_before");
    push_rdy(51, 1'b0, "t4_rdy_taken");
    push_rdy(60, 1'b0, "t4_rdy_mid");
    push_rdy(68, 1'b0, "t4_rdy_fd");
    push_rdy(69, 1'b1, "t4_rdy_back");
    push_rdy(70, 1'b0, "t4_rdy_second");
    exp_frame(68, 12'h1DE, 12'h200, 12'h4FC, 12'h877, 1'b0, 20, "t3_frame_abcd");
    send(16'hABCD, 4'b0101, 4'b0010);
    push_rdy(88, 1'b0, "t4_rdy_fd2");
    push_rdy(89, 1'b1, "t4_rdy_back2");
    exp_frame(88, 12'h17D, 12'h207, 12'h47F, 12'h86F, 1'b0, 20, "t4_frame_9876");
    send(16'h9876, 4'h0, 4'h0);

    // 5. Load presented in the frame_done cycle with nothing pending.
    wait_cyc(108);
    exp_frame(108, 12'h17D, 12'h207, 12'h47F, 12'h86F, 1'b0, 20, "t5_frame_hold");
    push_rdy(108, 1'b1, "t5_rdy_fd");
    push_rdy(109, 1'b0, "t5_rdy_taken");
    push_rdy(128, 1'b0, "t5_rdy_fd2");
    push_rdy(129, 1'b1, "t5_rdy_back");
    exp_frame(128, 12'h177, 12'h26D, 12'h439, 12'h8CF, 1'b0, 13, "t5_frame_3c5a");
    send(16'h3C5A, 4'b1000, 4'h0);

    // 6. Disable during digit-2 SHOW, load FFFF while dark, re-enable.
    wait_cyc(140);
    en = 1'b0;
    for (int c = 141; c <= 145; c++) push_disp(c, 12'h000, 1'b0, "t6_dark");
    push_rdy(141, 1'b1, "t6_rdy_dis");
    push_rdy(142, 1'b0, "t6_rdy_taken");
    push_rdy(143, 1'b0, "t6_rdy_commit");
    push_rdy(144, 1'b1, "t6_rdy_back");
    wait_cyc(141);
    send(16'hFFFF, 4'h0, 4'h0);
    wait_cyc(146);
    en = 1'b1;
    exp_frame(146, 12'h171, 12'h271, 12'h471, 12'h871, 1'b1, 20, "t6_frame_restart");
    exp_frame(166, 12'h171, 12'h271, 12'h471, 12'h871, 1'b0, 20, "t6_frame_next");

    wait_cyc(190);
    step();
    step();
    // Anything left unchecked is a missed observation.
    while (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL %s never checked at cyc=%0d (now %0d)", exp_q[0].tag, exp_q[0].cyc, cyc);
      void'(exp_q.pop_front());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
